ram64_march_bist: RTL and testbench
===================================

// Module: ram64_march_bist
// PURPOSE
//  Built-in self-test initiator for the RAM64 word memory. Drives the memory's addr/in/write port and checks its out port.
//  Runs a March C- sequence over all 64 words and reports pass/fail with the first failing address.
//  Sits between the test controller (start/done) and one RAM64 instance; it is the memory's only master while busy.
// PARAMETERS
//  ADDR_W   6         address width; the depth is 2**ADDR_W words
//  DATA_W   16        word width
//  PATTERN  16'h0000  background B0; B1 = ~PATTERN
// PORTS
//  clk          in   1       system clock
//  reset        in   1       synchronous, active-high reset
//  start        in   1       launch test (sampled in IDLE/PASS/FAIL only)
//  busy         out  1       test in progress
//  done         out  1       test finished (held until the next start or reset)
//  pass         out  1       valid when done=1; 1 = no mismatch
//  fail_addr    out  ADDR_W  address of first mismatch
//  fail_data    out  DATA_W  mem_out at first mismatch
//  fail_expect  out  DATA_W  expected word at first mismatch
//  mem_addr     out  ADDR_W  to RAM64 addr
//  mem_in       out  DATA_W  to RAM64 in
//  mem_write    out  1       to RAM64 write
//  mem_out      in   DATA_W  from RAM64 out (combinational read of mem_addr)
// BEHAVIOUR
//  Clock and reset: one clock, clk. Reset is synchronous and active-high.
//  Reset values: every output is 0. The FSM goes to IDLE. A reset mid-run aborts at that edge with mem_write=0.
//   RAM contents are then undefined.
//  FSM states:
//   IDLE -start-> RUN
//   RUN -last op, no fail-> PASS
//   RUN -mismatch-> FAIL
//   PASS/FAIL -start-> RUN (clears done, pass, fail_*)
//   start is ignored in RUN.
//  March elements, one op per cycle:
//   M0 up   (w B0)
//   M1 up   (r B0, w B1)
//   M2 up   (r B1, w B0)
//   M3 down (r B0, w B1)
//   M4 down (r B1, w B0)
//   M5 up   (r B0)
//  Address sequencing: up runs 0..63 and down runs 63..0. An element ends at 63 (up) or 0 (down).
//   The 6-bit address wrap is never used to end an element.
//  Total: 640 op cycles (320 writes, 320 reads).
//  mem_addr/mem_in/mem_write are combinational decodes of the registered element/addr/phase.
//   mem_write=1 only on write ops in RUN. mem_in=0 on read ops.
//  Read op: mem_out is compared with the expected word at the clk edge that ends that cycle.
//   A written value is readable from the following cycle.
//  Timing: busy=1 exactly while in RUN. done/pass rise on the edge after the last op.
//   That is 640 edges after the edge that sampled start, if no fail occurs.
//  Mismatch: fail_addr/fail_data/fail_expect capture the values on that edge.
// CONFIGURATION
//  RAM64_BIST_ERRCNT_EN defined:
//   - A mismatch does not stop the test. All 640 ops always run.
//   - fail_* still hold the first mismatch.
//   - Extra output err_count[7:0] counts mismatching reads, saturating at 255. Reset and start clear it.
//   - The end state is FAIL if err_count is nonzero, otherwise PASS.
//  Not defined: the FSM goes to FAIL on the first mismatch (done=1, pass=0). There is no err_count port.
// STRUCTURE
//  Package ram64_bist_pkg:
//   - ADDR_W/DATA_W defaults
//   - state encoding (IDLE, RUN, PASS, FAIL)
//   - element index M0..M5
//   - per-element direction, read value and write value tables
//  Sub-module ram64_bist_seq: element/phase/address counter. Inputs: advance, clear. Outputs: element, phase, addr, last_op.
//  The top level holds the FSM, the compare logic and the fail capture.
// TESTING
//  1. Fault-free RAM64, PATTERN=0, 1-cycle start:
//     busy=1 for 640 cycles, then done=1 and pass=1.
//     Monitor counts 320 writes and 320 reads.
//  2. Model with addr 6'h2A bit3 stuck-at-1:
//     done=1, pass=0, fail_addr=6'h2A, fail_expect=16'h0000, fail_data=16'h0008.
//     This occurs on the M1 read, 148 cycles after start.
//  3. reset asserted at RUN cycle 100:
//     next cycle busy=0, done=0, pass=0, mem_write=0.
//     A later start completes a full 640-cycle run.
//  4. start pulsed at RUN cycle 50: ignored, run ends at cycle 640.
//     start in PASS: done falls next cycle, then the run repeats.
//  5. PATTERN=16'h5555: every mem_in during a write is 16'h5555 or 16'hAAAA. pass=1.
//  6. RAM64_BIST_ERRCNT_EN, addr 5 bit0 stuck-at-1:
//     all 640 ops run, err_count=3 (M1, M3, M5 reads), fail_addr=5, pass=0.

Source files
------------

// File: rtl/ram64_bist_pkg.sv
// Shared types and March C- element tables for the RAM64 BIST.
package ram64_bist_pkg;

  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DATA_W = 16;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PASS, ST_FAIL} state_t;

  typedef enum logic [2:0] {M0, M1, M2, M3, M4, M5} elem_t;

  // Element walks the address space downward.
  function automatic logic elem_down(input elem_t e);
    return (e == M3) || (e == M4);
  endfunction

  // Element starts with a read.
  function automatic logic has_read(input elem_t e);
    return e != M0;
  endfunction

  // Element ends with a write.
  function automatic logic has_write(input elem_t e);
    return e != M5;
  endfunction

  // Read expects B1 (~PATTERN) instead of B0.
  function automatic logic read_inv(input elem_t e);
    return (e == M2) || (e == M4);
  endfunction

  // Write stores B1 (~PATTERN) instead of B0.
  function automatic logic write_inv(input elem_t e);
    return (e == M1) || (e == M3);
  endfunction

endpackage

// File: rtl/ram64_bist_seq.sv
// Element / phase / address sequencer for the March C- walk.
module ram64_bist_seq #(
  parameter int unsigned ADDR_W = ram64_bist_pkg::ADDR_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  advance,
  input  logic                  clear,
  output ram64_bist_pkg::elem_t element,
  output logic                  phase,
  output logic [ADDR_W-1:0]     addr,
  output logic                  last_op
);
  import ram64_bist_pkg::*;

  logic  last_phase;
  logic  at_end;
  elem_t next_elem;

  // Position decode: last op of the element at this address, and end of element.
  always_comb begin
    last_phase = (phase == (has_read(element) && has_write(element)));
    at_end     = elem_down(element) ? (addr == '0) : (addr == '1);
    next_elem  = elem_t'(3'(element) + 3'd1);
    last_op    = (element == M5) && at_end && last_phase;
  end

  // Step one op per advance; elements end on an explicit address compare.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      element <= M0;
      phase   <= 1'b0;
      addr    <= '0;
    end else if (advance) begin
      if (!last_phase) begin
        phase <= 1'b1;
      end else begin
        phase <= 1'b0;
        if (at_end) begin
          if (element != M5) begin
            element <= next_elem;
            addr    <= elem_down(next_elem) ? '1 : '0;
          end
        end else begin
          addr <= elem_down(element) ? addr - ADDR_W'(1) : addr + ADDR_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/ram64_march_bist.sv
// March C- BIST initiator for one RAM64 instance.
// Optional feature: define RAM64_BIST_ERRCNT_EN to run all ops and count mismatches.
module ram64_march_bist #(
  parameter int unsigned       ADDR_W  = ram64_bist_pkg::ADDR_W,
  parameter int unsigned       DATA_W  = ram64_bist_pkg::DATA_W,
  parameter logic [DATA_W-1:0] PATTERN = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data,
  output logic [DATA_W-1:0] fail_expect,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_in,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_out
`ifdef RAM64_BIST_ERRCNT_EN
  ,
  output logic [7:0]        err_count
`endif
);
  import ram64_bist_pkg::*;

  state_t            state, state_nx;
  elem_t             element;
  logic              phase;
  logic [ADDR_W-1:0] addr;
  logic              last_op;
  logic              run, start_accept, is_read, is_write, mismatch, first_err;
  logic [DATA_W-1:0] expect_word;

  ram64_bist_seq #(.ADDR_W(ADDR_W)) u_seq (
    .clk     (clk),
    .reset   (reset),
    .advance (run),
    .clear   (start_accept),
    .element (element),
    .phase   (phase),
    .addr    (addr),
    .last_op (last_op)
  );

  // Op decode, memory port drive and read compare.
  always_comb begin
    run          = (state == ST_RUN);
    start_accept = start && !run;
    is_read      = has_read(element) && !phase;
    is_write     = has_write(element) && (phase || !has_read(element));
    expect_word  = read_inv(element) ? ~PATTERN : PATTERN;
    mem_addr     = '0;
    mem_in       = '0;
    mem_write    = 1'b0;
    if (run) begin
      mem_addr = addr;
      if (is_write) begin
        mem_write = 1'b1;
        mem_in    = write_inv(element) ? ~PATTERN : PATTERN;
      end
    end
    mismatch = run && is_read && (mem_out != expect_word);
`ifdef RAM64_BIST_ERRCNT_EN
    first_err = (err_count == 8'd0);
`else
    first_err = 1'b1;
`endif
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE, ST_PASS, ST_FAIL: if (start) state_nx = ST_RUN;
      ST_RUN: begin
`ifdef RAM64_BIST_ERRCNT_EN
        if (last_op) state_nx = (mismatch || (err_count != 8'd0)) ? ST_FAIL : ST_PASS;
`else
        if (mismatch)     state_nx = ST_FAIL;
        else if (last_op) state_nx = ST_PASS;
`endif
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Registered status, first-failure capture and error count.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      fail_addr   <= '0;
      fail_data   <= '0;
      fail_expect <= '0;
`ifdef RAM64_BIST_ERRCNT_EN
      err_count   <= '0;
`endif
    end else begin
      busy <= (state_nx == ST_RUN);
      done <= (state_nx == ST_PASS) || (state_nx == ST_FAIL);
      pass <= (state_nx == ST_PASS);
      if (start_accept) begin
        fail_addr   <= '0;
        fail_data   <= '0;
        fail_expect <= '0;
      end else if (mismatch && first_err) begin
        fail_addr   <= addr;
        fail_data   <= mem_out;
        fail_expect <= expect_word;
      end
`ifdef RAM64_BIST_ERRCNT_EN
      if (start_accept)                           err_count <= '0;
      else if (mismatch && (err_count != 8'hFF))  err_count <= err_count + 8'd1;
`endif
    end
  end

endmodule

// File: tb/tb_ram64_march_bist.sv
// Scoreboard bench for ram64_march_bist with a fault-injectable RAM64 model.
module tb_ram64_march_bist;

  typedef struct {
    int          start_cyc;
    int          lat;
    bit          pass;
    int          fa;
    logic [15:0] fd;
    logic [15:0] fe;
    int          ec;
    int          wr;
    int          rd;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  exp_t q[$];

  // DUT0: PATTERN 0, faulty RAM
  logic        busy0, done0, pass0, mem_write0;
  logic [5:0]  fail_addr0, mem_addr0;
  logic [15:0] fail_data0, fail_expect0, mem_in0, mem_out0;
  logic [15:0] ram0 [64];
  logic [5:0]  fault_addr = 6'd0;
  logic [15:0] or_m = 16'h0, and_m = 16'h0;
  // DUT1: PATTERN 5555, fault-free RAM
  logic        busy1, done1, pass1, mem_write1;
  logic [5:0]  fail_addr1, mem_addr1;
  logic [15:0] fail_data1, fail_expect1, mem_in1, mem_out1;
  logic [15:0] ram1 [64];
`ifdef RAM64_BIST_ERRCNT_EN
  logic [7:0]  err_count0, err_count1;
`endif

  ram64_march_bist dut0 (
    .clk(clk), .reset(reset), .start(start), .busy(busy0), .done(done0), .pass(pass0),
    .fail_addr(fail_addr0), .fail_data(fail_data0), .fail_expect(fail_expect0),
    .mem_addr(mem_addr0), .mem_in(mem_in0), .mem_write(mem_write0), .mem_out(mem_out0)
`ifdef RAM64_BIST_ERRCNT_EN
    , .err_count(err_count0)
`endif
  );

  ram64_march_bist #(.PATTERN(16'h5555)) dut1 (
    .clk(clk), .reset(reset), .start(start), .busy(busy1), .done(done1), .pass(pass1),
    .fail_addr(fail_addr1), .fail_data(fail_data1), .fail_expect(fail_expect1),
    .mem_addr(mem_addr1), .mem_in(mem_in1), .mem_write(mem_write1), .mem_out(mem_out1)
`ifdef RAM64_BIST_ERRCNT_EN
    , .err_count(err_count1)
`endif
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM64 models: synchronous write, combinational read, optional stuck bits on dut0.
  always @(posedge clk) begin
    if (mem_write0) ram0[mem_addr0] <= mem_in0;
    if (mem_write1) ram1[mem_addr1] <= mem_in1;
  end
  assign mem_out0 = (mem_addr0 == fault_addr) ? ((ram0[mem_addr0] & ~and_m) | or_m)
                                              : ram0[mem_addr0];
  assign mem_out1 = ram1[mem_addr1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // March C- reference: walk the six elements on an array, apply the read fault.
  function automatic exp_t model(input logic [15:0] pat, input int fa,
                                 input logic [15:0] om, input logic [15:0] am);
    logic [15:0] m [64];
    int          dn  [6] = '{0, 0, 0, 1, 1, 0};
    int          hr  [6] = '{0, 1, 1, 1, 1, 1};
    int          rb1 [6] = '{0, 0, 1, 0, 1, 0};
    int          hw  [6] = '{1, 1, 1, 1, 1, 0};
    int          wb1 [6] = '{0, 1, 0, 1, 0, 0};
    logic [15:0] got, ew;
    exp_t        r;
    int          a;
    bit          stop = 0;
    r = '{default: 0};
    r.pass = 1;
    for (int e = 0; e < 6; e++) begin
      for (int i = 0; i < 64; i++) begin
        if (stop) break;
        a = (dn[e] != 0) ? 63 - i : i;
        if (hr[e] != 0) begin
          r.lat++;
          r.rd++;
          got = (a == fa) ? ((m[a] & ~am) | om) : m[a];
          ew  = (rb1[e] != 0) ? ~pat : pat;
          if (got != ew) begin
            if (r.pass) begin
              r.fa = a; r.fd = got; r.fe = ew;
            end
            r.pass = 0;
            if (r.ec < 255) r.ec++;
`ifndef RAM64_BIST_ERRCNT_EN
            stop = 1;
`endif
          end
        end
        if (!stop && hw[e] != 0) begin
          r.lat++;
          r.wr++;
          m[a] = (wb1[e] != 0) ? ~pat : pat;
        end
      end
    end
    return r;
  endfunction

  // Monitor: pop the scoreboard on each done rise; count ops while busy.
  initial begin
    bit pbusy0 = 0, pdone0 = 0, pdone1 = 0, pbusy1 = 0;
    int wr0 = 0, rd0 = 0, wr1 = 0, bad1 = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (busy0 === 1'b1 && !pbusy0) begin wr0 = 0; rd0 = 0; end
      if (busy0 === 1'b1) begin
        if (mem_write0) wr0++;
        else rd0++;
      end
      if (busy1 === 1'b1 && !pbusy1) begin wr1 = 0; bad1 = 0; end
      if (busy1 === 1'b1 && mem_write1) begin
        wr1++;
        if (mem_in1 != 16'h5555 && mem_in1 != 16'hAAAA) bad1++;
      end
      if (done0 === 1'b1 && !pdone0) begin
        if (q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_done: got done with empty scoreboard (cycle %0d)", cyc);
        end else begin
          e = q.pop_front();
          chk("latency", 32'(cyc - e.start_cyc), 32'(e.lat));
          chk("pass", 32'(pass0), 32'(e.pass));
          chk("fail_addr", 32'(fail_addr0), 32'(e.fa));
          chk("fail_data", 32'(fail_data0), 32'(e.fd));
          chk("fail_expect", 32'(fail_expect0), 32'(e.fe));
          chk("write_count", 32'(wr0), 32'(e.wr));
          chk("read_count", 32'(rd0), 32'(e.rd));
`ifdef RAM64_BIST_ERRCNT_EN
          chk("err_count", 32'(err_count0), 32'(e.ec));
`endif
        end
      end
      if (done1 === 1'b1 && !pdone1) begin
        chk("p5555_pass", 32'(pass1), 32'd1);
        chk("p5555_writes", 32'(wr1), 32'd320);
        chk("p5555_bad_mem_in", 32'(bad1), 32'd0);
      end
      pbusy0 = (busy0 === 1'b1);
      pdone0 = (done0 === 1'b1);
      pbusy1 = (busy1 === 1'b1);
      pdone1 = (done1 === 1'b1);
    end
  end

  task automatic wait_done();
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if (done0 && done1) break;
    end
    chk("done_within_budget", 32'(done0 && done1), 32'd1);
  endtask

  // One start pulse; optional ignored start pulse at about RUN cycle ign.
  task automatic run(input int fa, input logic [15:0] om, input logic [15:0] am, input int ign);
    exp_t e;
    fault_addr = 6'(fa);
    or_m  = om;
    and_m = am;
    e = model(16'h0000, fa, om, am);
    @(negedge clk);
    start = 1'b1;
    e.start_cyc = cyc + 1;
    q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    chk("start_enters_run", 32'({busy0, done0, pass0}), 32'b100);
    chk("start_clears_fail_addr", 32'(fail_addr0), 32'd0);
    if (ign > 0) begin
      repeat (ign - 1) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    wait_done();
  endtask

  task automatic check_idle(input string name);
    chk({name, "_dut0"}, 32'({busy0, done0, pass0, mem_write0}), 32'd0);
    chk({name, "_dut0_fail"}, 32'({fail_addr0, fail_data0}), 32'd0);
    chk({name, "_dut0_mem"}, 32'({mem_addr0, mem_in0}), 32'd0);
    chk({name, "_dut1"}, 32'({busy1, done1, pass1, mem_write1}), 32'd0);
  endtask

  initial begin
    int fa, b, kind;
    repeat (3) @(negedge clk);
    check_idle("reset_values");
    reset = 1'b0;

    run(0, 16'h0, 16'h0, 0);                 // fault-free
    run(6'h2A, 16'h0008, 16'h0, 0);          // addr 2A bit3 stuck-at-1
    // reset during RUN aborts the test
    fault_addr = 6'd0; or_m = 16'h0; and_m = 16'h0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (99) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_idle("reset_mid_run");
    reset = 1'b0;
    run(0, 16'h0, 16'h0, 0);                 // full run after abort
    run(0, 16'h0, 16'h0, 50);                // start ignored in RUN
    run(0, 16'h0, 16'h0, 0);                 // start from PASS repeats
    run(5, 16'h0001, 16'h0, 0);              // addr 5 bit0 stuck-at-1
    run(63, 16'h0, 16'h8000, 0);             // stuck-at-0 at top address
    run(0, 16'h0, 16'h0, 0);                 // start from FAIL

    for (int k = 0; k < 6; k++) begin
      kind = $urandom_range(0, 2);
      fa   = $urandom_range(0, 63);
      b    = $urandom_range(0, 15);
      repeat ($urandom_range(0, 4)) @(negedge clk);
      run(fa, (kind == 1) ? 16'(1 << b) : 16'h0, (kind == 2) ? 16'(1 << b) : 16'h0, 0);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
